// File: rtl/dls_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dls_pkg
// Brief    : Shared types and helpers for the dual-lockstep fault controller.
// Revision : 1.0 - initial release
// ============================================================================
package dls_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        MONITOR    = 3'd1,
        CONFIRM    = 3'd2,
        RESET_PAIR = 3'd3,
        SETTLE     = 3'd4,
        FAILED     = 3'd5
    } dls_state_t;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int dls_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dls_cycle_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dls_cycle_timer
// Brief    : Loadable down-counter; o_expire is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module dls_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_run,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dls_fault_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dls_fault_ctrl
// Brief    : Debounce, pair-reset and retry sequencer for the lockstep VGA pair.
//            Optional DLS_FAULT_LOG_EN adds ERR_TOTAL / FIRST_ERR_TS logging.
// Revision : 1.0 - initial release
// ============================================================================
module dls_fault_ctrl #(
    parameter  int DEBOUNCE      = 4,
    parameter  int RST_CYCLES    = 8,
    parameter  int SETTLE_CYCLES = 16,
    parameter  int MAX_RETRIES   = 3,
    parameter  int CLEAN_CYCLES  = 1024,
    localparam int RETRY_W       = $clog2(MAX_RETRIES + 1)
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               ENABLE,
    input  logic               DLS_ERROR,
    input  logic               CLR_FAULT,
    output logic               PAIR_RESET,
    output logic               COMP_MASK,
    output logic               FAULT_IRQ,
    output logic               FAILED,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic [2:0]         STATE
`ifdef DLS_FAULT_LOG_EN
    ,
    output logic [15:0]        ERR_TOTAL,
    output logic [31:0]        FIRST_ERR_TS
`endif
);

    import dls_pkg::*;

    localparam int c_ERR_W = dls_width(DEBOUNCE);
    localparam int c_TMR_W = dls_width(((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) - 1);
    localparam int c_CLN_W = dls_width(CLEAN_CYCLES - 1);

    dls_state_t          r_state;
    dls_state_t          w_next;
    logic [c_ERR_W-1:0]  r_err_cnt;
    logic [c_ERR_W-1:0]  w_err_next;
    logic [RETRY_W-1:0]  r_retry;
    logic [RETRY_W-1:0]  w_retry_eff;
    logic [RETRY_W-1:0]  w_retry_next;
    logic                w_declare;
    logic                w_tmr_load;
    logic [c_TMR_W-1:0]  w_tmr_val;
    logic                w_tmr_exp;
    logic                w_cln_load;
    logic                w_cln_exp;
    logic                w_cln_clear;

    // A same-cycle clear takes precedence over the stored count for the retry decision.
    assign w_retry_eff = CLR_FAULT ? '0 : r_retry;

    always_comb begin
        w_next     = r_state;
        w_err_next = '0;
        w_declare  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = c_TMR_W'(RST_CYCLES - 1);
        case (r_state)
            IDLE: begin
                if (ENABLE) w_next = MONITOR;
            end
            MONITOR: begin
                if (DLS_ERROR) begin
                    if (DEBOUNCE == 1) begin
                        w_declare = 1'b1;
                    end else begin
                        w_next     = CONFIRM;
                        w_err_next = c_ERR_W'(1);
                    end
                end
            end
            CONFIRM: begin
                if (DLS_ERROR) begin
                    w_err_next = r_err_cnt + 1'b1;
                    if (w_err_next == c_ERR_W'(DEBOUNCE)) w_declare = 1'b1;
                end else begin
                    w_next = MONITOR;
                end
            end
            RESET_PAIR: begin
                if (w_tmr_exp) begin
                    w_next     = SETTLE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (w_tmr_exp) w_next = MONITOR;
            end
            dls_pkg::FAILED: begin
                if (CLR_FAULT) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        if (w_declare) begin
            w_tmr_load = 1'b1;
            if (w_retry_eff < RETRY_W'(MAX_RETRIES)) w_next = RESET_PAIR;
            else                                      w_next = dls_pkg::FAILED;
        end

        // Supervision off abandons any sequence; a latched fault ignores ENABLE.
        if (!ENABLE && (r_state != dls_pkg::FAILED)) begin
            w_next    = IDLE;
            w_declare = 1'b0;
        end
    end

    assign w_cln_load  = (r_state != MONITOR) || DLS_ERROR || w_cln_exp;
    assign w_cln_clear = (r_state == MONITOR) && ENABLE && !DLS_ERROR && w_cln_exp;

    always_comb begin
        w_retry_next = r_retry;
        if (CLR_FAULT || w_cln_clear) w_retry_next = '0;
        if (w_declare && (w_next == RESET_PAIR)) w_retry_next = w_retry_eff + 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= IDLE;
            r_err_cnt  <= '0;
            r_retry    <= '0;
            PAIR_RESET <= 1'b0;
            COMP_MASK  <= 1'b0;
            FAULT_IRQ  <= 1'b0;
            FAILED     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err_cnt  <= w_err_next;
            r_retry    <= w_retry_next;
            PAIR_RESET <= (w_next == RESET_PAIR);
            COMP_MASK  <= (w_next == RESET_PAIR) || (w_next == SETTLE);
            FAULT_IRQ  <= w_declare;
            FAILED     <= (w_next == dls_pkg::FAILED);
        end
    end

    assign STATE     = r_state;
    assign RETRY_CNT = r_retry;

    dls_cycle_timer #(.W(c_TMR_W)) u_seq_tmr (
        .clk        (HCLK),
        .rst        (HRESET),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_run      (1'b1),
        .o_expire   (w_tmr_exp)
    );

    dls_cycle_timer #(.W(c_CLN_W)) u_clean_tmr (
        .clk        (HCLK),
        .rst        (HRESET),
        .i_load     (w_cln_load),
        .i_load_val (c_CLN_W'(CLEAN_CYCLES - 1)),
        .i_run      (1'b1),
        .o_expire   (w_cln_exp)
    );

`ifdef DLS_FAULT_LOG_EN
    logic [31:0] r_cyc;
    logic        r_ts_valid;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_cyc        <= '0;
            r_ts_valid   <= 1'b0;
            ERR_TOTAL    <= '0;
            FIRST_ERR_TS <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_declare && (ERR_TOTAL != 16'hFFFF)) ERR_TOTAL <= ERR_TOTAL + 16'd1;
            if (w_declare && (!r_ts_valid || CLR_FAULT)) begin
                FIRST_ERR_TS <= r_cyc;
                r_ts_valid   <= 1'b1;
            end else if (CLR_FAULT) begin
                FIRST_ERR_TS <= '0;
                r_ts_valid   <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dls_fault_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dls_fault_ctrl
// Brief    : Directed self-checking bench for dls_fault_ctrl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dls_fault_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_enable = 1'b0;
    logic       r_err = 1'b0;
    logic       r_clr = 1'b0;
    logic       w_pair_reset;
    logic       w_comp_mask;
    logic       w_fault_irq;
    logic       w_failed;
    logic [1:0] w_retry_cnt;
    logic [2:0] w_state;
`ifdef DLS_FAULT_LOG_EN
    logic [15:0] w_err_total;
    logic [31:0] w_first_ts;
    logic [31:0] r_cyc_model;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dls_fault_ctrl u_dut (
        .HCLK         (clk),
        .HRESET       (rst),
        .ENABLE       (r_enable),
        .DLS_ERROR    (r_err),
        .CLR_FAULT    (r_clr),
        .PAIR_RESET   (w_pair_reset),
        .COMP_MASK    (w_comp_mask),
        .FAULT_IRQ    (w_fault_irq),
        .FAILED       (w_failed),
        .RETRY_CNT    (w_retry_cnt),
        .STATE        (w_state)
`ifdef DLS_FAULT_LOG_EN
        ,
        .ERR_TOTAL    (w_err_total),
        .FIRST_ERR_TS (w_first_ts)
`endif
    );

`ifdef DLS_FAULT_LOG_EN
    always @(posedge clk or posedge rst) begin
        if (rst) r_cyc_model <= '0;
        else     r_cyc_model <= r_cyc_model + 32'd1;
    end
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; r_enable = 1'b0; r_err = 1'b0; r_clr = 1'b0;
        tick(2);
        n_tests++;
        if (w_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", w_state);
        end
        n_tests++;
        if ({w_pair_reset, w_comp_mask, w_fault_irq, w_failed, w_retry_cnt} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000",
                {w_pair_reset, w_comp_mask, w_fault_irq, w_failed, w_retry_cnt});
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        r_enable = 1'b1;
        tick(1);
        n_tests++;
        if (w_state !== 3'd1) begin
            n_fail++; $display("FAIL enable_to_monitor: got %0d want 1", w_state);
        end
        r_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (w_pair_reset || w_fault_irq || w_comp_mask) bad++;
        end
        n_tests++;
        if (w_state !== 3'd2) begin
            n_fail++; $display("FAIL glitch_confirm: got %0d want 2", w_state);
        end
        r_err = 1'b0;
        tick(1);
        if (w_pair_reset || w_fault_irq || w_comp_mask) bad++;
        n_tests++;
        if ({w_state, w_retry_cnt} !== {3'd1, 2'd0}) begin
            n_fail++; $display("FAIL glitch_back: got state %0d retry %0d want 1/0", w_state, w_retry_cnt);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL glitch_no_reset: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_recovery();
        int n_pr, n_mk, n_irq;
        logic [2:0] st8, st24;
        n_pr = 0; n_mk = 0; n_irq = 0; st8 = '0; st24 = '0;
        r_err = 1'b1;
        tick(3);
        n_tests++;
        if ({w_state, w_pair_reset} !== {3'd2, 1'b0}) begin
            n_fail++; $display("FAIL latency_before: got state %0d pr %0b want 2/0", w_state, w_pair_reset);
        end
        tick(1);
        r_err = 1'b0;
        n_tests++;
        if ({w_state, w_pair_reset, w_fault_irq, w_retry_cnt} !== {3'd3, 1'b1, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL recovery_entry: got state %0d pr %0b irq %0b retry %0d want 3/1/1/1",
                w_state, w_pair_reset, w_fault_irq, w_retry_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            n_pr  += int'(w_pair_reset);
            n_mk  += int'(w_comp_mask);
            n_irq += int'(w_fault_irq);
            if (i == 8)  st8  = w_state;
            if (i == 24) st24 = w_state;
            tick(1);
        end
        n_tests++;
        if (n_pr !== 8) begin
            n_fail++; $display("FAIL pair_reset_len: got %0d want 8", n_pr);
        end
        n_tests++;
        if (n_mk !== 24) begin
            n_fail++; $display("FAIL comp_mask_len: got %0d want 24", n_mk);
        end
        n_tests++;
        if (n_irq !== 1) begin
            n_fail++; $display("FAIL irq_pulses: got %0d want 1", n_irq);
        end
        n_tests++;
        if ({st8, st24, w_state} !== {3'd4, 3'd1, 3'd1}) begin
            n_fail++; $display("FAIL recovery_states: got %0d/%0d/%0d want 4/1/1", st8, st24, w_state);
        end
    endtask

    task automatic test_decay();
        r_enable = 1'b0;
        tick(1);
        n_tests++;
        if ({w_state, w_retry_cnt} !== {3'd0, 2'd1}) begin
            n_fail++; $display("FAIL disable_keeps_retry: got state %0d retry %0d want 0/1", w_state, w_retry_cnt);
        end
        r_enable = 1'b1;
        tick(1);
        tick(1023);
        n_tests++;
        if (w_retry_cnt !== 2'd1) begin
            n_fail++; $display("FAIL decay_1023: got %0d want 1", w_retry_cnt);
        end
        tick(1);
        n_tests++;
        if (w_retry_cnt !== 2'd0) begin
            n_fail++; $display("FAIL decay_1024: got %0d want 0", w_retry_cnt);
        end
    endtask

    task automatic test_exhaust();
        for (int k = 1; k <= 4; k++) begin
            r_err = 1'b1;
            tick(4);
            r_err = 1'b0;
            if (k < 4) begin
                n_tests++;
                if ({w_fault_irq, w_pair_reset, w_retry_cnt} !== {1'b1, 1'b1, 2'(k)}) begin
                    n_fail++; $display("FAIL exhaust_retry%0d: got irq %0b pr %0b retry %0d want 1/1/%0d",
                        k, w_fault_irq, w_pair_reset, w_retry_cnt, k);
                end
                tick(24);
                n_tests++;
                if (w_state !== 3'd1) begin
                    n_fail++; $display("FAIL exhaust_monitor%0d: got %0d want 1", k, w_state);
                end
            end else begin
                n_tests++;
                if ({w_failed, w_fault_irq, w_pair_reset, w_comp_mask, w_state, w_retry_cnt}
                        !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 2'd3}) begin
                    n_fail++; $display("FAIL exhaust_failed: got f %0b irq %0b pr %0b m %0b st %0d r %0d want 1/1/0/0/5/3",
                        w_failed, w_fault_irq, w_pair_reset, w_comp_mask, w_state, w_retry_cnt);
                end
            end
        end
        tick(3);
        r_enable = 1'b0;
        tick(2);
        n_tests++;
        if ({w_failed, w_state, w_fault_irq, w_pair_reset} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL failed_sticky: got f %0b st %0d irq %0b pr %0b want 1/5/0/0",
                w_failed, w_state, w_fault_irq, w_pair_reset);
        end
        r_clr = 1'b1;
        tick(1);
        r_clr = 1'b0;
        n_tests++;
        if ({w_failed, w_retry_cnt, w_state} !== 6'b0) begin
            n_fail++; $display("FAIL clr_fault: got f %0b r %0d st %0d want 0/0/0", w_failed, w_retry_cnt, w_state);
        end
    endtask

    task automatic test_abort();
        r_enable = 1'b1;
        tick(1);
        r_err = 1'b1;
        tick(4);
        r_err = 1'b0;
        tick(2);
        n_tests++;
        if ({w_state, w_pair_reset} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL abort_setup: got state %0d pr %0b want 3/1", w_state, w_pair_reset);
        end
        r_enable = 1'b0;
        tick(1);
        n_tests++;
        if ({w_pair_reset, w_comp_mask, w_state, w_retry_cnt} !== {1'b0, 1'b0, 3'd0, 2'd1}) begin
            n_fail++; $display("FAIL abort_disable: got pr %0b m %0b st %0d r %0d want 0/0/0/1",
                w_pair_reset, w_comp_mask, w_state, w_retry_cnt);
        end
        r_enable = 1'b1;
        tick(1);
        r_err = 1'b1;
        tick(4);
        r_err = 1'b0;
        tick(10);
        n_tests++;
        if ({w_state, w_comp_mask, w_pair_reset, w_retry_cnt} !== {3'd4, 1'b1, 1'b0, 2'd2}) begin
            n_fail++; $display("FAIL settle_mid: got st %0d m %0b pr %0b r %0d want 4/1/0/2",
                w_state, w_comp_mask, w_pair_reset, w_retry_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({w_pair_reset, w_comp_mask, w_fault_irq, w_failed, w_retry_cnt, w_state} !== 9'b0) begin
            n_fail++; $display("FAIL async_reset: got %b want 000000000",
                {w_pair_reset, w_comp_mask, w_fault_irq, w_failed, w_retry_cnt, w_state});
        end
        r_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_clr_wins();
        r_enable = 1'b1;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            r_err = 1'b1;
            tick(4);
            r_err = 1'b0;
            tick(24);
        end
        n_tests++;
        if ({w_state, w_retry_cnt} !== {3'd1, 2'd3}) begin
            n_fail++; $display("FAIL clr_wins_setup: got st %0d r %0d want 1/3", w_state, w_retry_cnt);
        end
        r_err = 1'b1;
        tick(3);
        r_clr = 1'b1;
        tick(1);
        r_clr = 1'b0;
        r_err = 1'b0;
        n_tests++;
        if ({w_state, w_retry_cnt, w_fault_irq, w_failed} !== {3'd3, 2'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL clr_wins: got st %0d r %0d irq %0b f %0b want 3/1/1/0",
                w_state, w_retry_cnt, w_fault_irq, w_failed);
        end
        tick(30);
    endtask

`ifdef DLS_FAULT_LOG_EN
    task automatic test_log();
        logic [31:0] ts_exp;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        r_enable = 1'b1;
        tick(1);
        r_err = 1'b1;
        tick(3);
        ts_exp = r_cyc_model;
        tick(1);
        r_err = 1'b0;
        tick(24);
        r_err = 1'b1;
        tick(4);
        r_err = 1'b0;
        n_tests++;
        if (w_err_total !== 16'd2) begin
            n_fail++; $display("FAIL log_total: got %0d want 2", w_err_total);
        end
        n_tests++;
        if (w_first_ts !== ts_exp) begin
            n_fail++; $display("FAIL log_first_ts: got %0d want %0d", w_first_ts, ts_exp);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_glitch();
        test_recovery();
        test_decay();
        test_exhaust();
        test_abort();
        test_clr_wins();
`ifdef DLS_FAULT_LOG_EN
        test_log();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
